traffic_light_sequencer: RTL
============================

# traffic_light_sequencer

Sequences the two-road (north-south / east-west) traffic lights from the timing values and run state set by the menu controller. It is the run-time engine behind the SIMULATION menu: it consumes `green_duration`, `yellow_duration`, `red_holding` and `sim_state`. It drives per-road one-hot light outputs plus phase and countdown information for the display and VGA renderer.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clock cycles per one-second tick; set to 4 in simulation.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `sim_state` input 2: 0 = STOP, 1 = PLAY, 2 = PAUSE; 3 is treated as STOP.
- `green_duration` input 8: green time in seconds, range 1..99.
- `yellow_duration` input 8: yellow time in seconds, range 1..99.
- `red_holding` input 8: all-red clearance time in seconds, range 1..99.
- `ns_light` output 3: north-south lamps, one-hot {red, yellow, green}.
- `ew_light` output 3: east-west lamps, one-hot {red, yellow, green}.
- `phase` output 3: current phase code.
- `sec_remaining` output 8: seconds left in the current phase.
- `sec_tick` output 1: one-cycle pulse on each counted second.

## Operation
- **Phases**, with codes and lamp patterns:
  - IDLE = 0: both roads red.
  - NS_GREEN = 1: NS green, EW red.
  - NS_YELLOW = 2: NS yellow, EW red.
  - RED_A = 3: both red.
  - EW_GREEN = 4: NS red, EW green.
  - EW_YELLOW = 5: NS red, EW yellow.
  - RED_B = 6: both red.
- **Cycle order**: NS_GREEN → NS_YELLOW → RED_A → EW_GREEN → EW_YELLOW → RED_B → NS_GREEN. It wraps indefinitely.
- **Phase durations**: green phases use `green_duration`, yellow phases use `yellow_duration`, RED_A and RED_B use `red_holding`.
- **Duration sampling**: a duration is sampled into `sec_remaining` only on entry to the phase. Changes made mid-phase take effect the next time that phase is entered. A sampled value of 0 is loaded as 1.
- **PLAY from IDLE**: enter NS_GREEN with `sec_remaining` = `green_duration`.
- **PLAY in any other phase**: the prescaler runs. Each `sec_tick` decrements `sec_remaining`. A tick while `sec_remaining` = 1 advances to the next phase and loads that phase's duration instead of decrementing.
- **PAUSE**: prescaler, `sec_remaining`, phase and lamps all freeze. PLAY resumes from the exact prescaler count. PAUSE while in IDLE stays in IDLE.
- **STOP**:
  - phase = IDLE, prescaler = 0, `sec_remaining` = 0, both lamps red.
  - This applies regardless of the current phase.
- **Lamp outputs**: decoded from `phase` only and registered. At no time is either road showing something other than exactly one lamp. At no time are both roads non-red.

## Timing
- **Reset values**:
  - phase = IDLE.
  - `ns_light` = `ew_light` = 3'b100.
  - `sec_remaining` = 0.
  - `sec_tick` = 0.
  - prescaler = 0.
- **`sim_state` reaction**: a change is acted on at the first clock edge after it is seen, so outputs reflect it one cycle later. STOP to PLAY gives NS_GREEN and `sec_remaining` = `green_duration` on that edge.
- **Prescaler**: counts 0..`TICKS_PER_SEC`-1 while in PLAY and not IDLE. `sec_tick` pulses for one cycle in the cycle the count wraps to 0. The first tick comes `TICKS_PER_SEC` cycles after entering PLAY from IDLE.
- **Phase length**: a phase of duration D lasts exactly D × `TICKS_PER_SEC` cycles in uninterrupted PLAY.
- **Tick and STOP together**: if a tick and STOP occur in the same cycle, STOP wins and the phase does not advance.
- **Tick and PAUSE together**: the tick for the cycle the pause is sampled is suppressed, because the prescaler freezes before wrapping.
- **Reset mid-operation**: asynchronous return to the reset values. The sequencer does not restart until `sim_state` is PLAY after reset deasserts.

## Structure
- **Shared package `traffic_pkg`** holds:
  - the SIM_STOP / SIM_PLAY / SIM_PAUSE codes (shared with the menu controller);
  - the phase codes;
  - the lamp one-hot constants RED = 3'b100, YEL = 3'b010, GRN = 3'b001.
- **Sub-module `sec_prescaler`**:
  - ports `clk`, `reset`, `run`, `clear`, `tick`;
  - parameter `TICKS_PER_SEC`.
- **Top level** keeps the phase FSM, countdown register and lamp decode.

## Test plan
Directed scenarios, all with `TICKS_PER_SEC` = 4:
- **Reset, then STOP held for 50 cycles** → phase 0, both lamps 3'b100, `sec_remaining` 0, no `sec_tick`.
- **PLAY with green = 2, yellow = 1, red = 1** → NS_GREEN for 8 cycles, NS_YELLOW 4, RED_A 4, EW_GREEN 8, EW_YELLOW 4, RED_B 4, then NS_GREEN again. `sec_remaining` reads 2, 1 during green.
- **PAUSE for 10 cycles at prescaler count 2 in EW_GREEN, then PLAY** → outputs frozen during the pause. The next `sec_tick` arrives 2 cycles after resume.
- **Change `green_duration` 3 → 5 during NS_GREEN** → the current green still lasts 3 s. The next NS_GREEN and EW_GREEN each last 5 s.
- **STOP asserted in NS_YELLOW in the same cycle as `sec_tick`** → next cycle phase IDLE, `sec_remaining` 0, no RED_A entry. A following PLAY restarts at NS_GREEN.
- **Async `reset` pulse mid EW_YELLOW between clock edges** → outputs go to reset values immediately. With PLAY held, NS_GREEN starts on the first edge after deassertion.

Source files
------------

// File: rtl/traffic_light_sequencer_pkg.sv
// Shared codes for the traffic light sequencer and the menu controller:
// run-state codes, phase codes, lamp patterns and small decode helpers.
package traffic_pkg;

  localparam logic [1:0] SIM_STOP  = 2'd0;
  localparam logic [1:0] SIM_PLAY  = 2'd1;
  localparam logic [1:0] SIM_PAUSE = 2'd2;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_RED_A     = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_RED_B     = 3'd6
  } phase_e;

  // Lamp one-hot patterns {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // A zero duration would stall the countdown, so it is treated as one second
  function automatic logic [7:0] sat_dur(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_NS_GREEN:  return PH_NS_YELLOW;
      PH_NS_YELLOW: return PH_RED_A;
      PH_RED_A:     return PH_EW_GREEN;
      PH_EW_GREEN:  return PH_EW_YELLOW;
      PH_EW_YELLOW: return PH_RED_B;
      default:      return PH_NS_GREEN;
    endcase
  endfunction

  function automatic logic [7:0] phase_duration(input phase_e p, input logic [7:0] green,
                                                input logic [7:0] yellow, input logic [7:0] red);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:   return sat_dur(green);
      PH_NS_YELLOW, PH_EW_YELLOW: return sat_dur(yellow);
      default:                    return sat_dur(red);
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input phase_e p);
    case (p)
      PH_NS_GREEN:  return GRN;
      PH_NS_YELLOW: return YEL;
      default:      return RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_e p);
    case (p)
      PH_EW_GREEN:  return GRN;
      PH_EW_YELLOW: return YEL;
      default:      return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Bundle between the menu controller (master) and the sequencer (slave):
// run state and timing settings in, lamps and countdown information out.
interface traffic_light_sequencer_if;
  logic [1:0] sim_state;
  logic [7:0] green_duration;
  logic [7:0] yellow_duration;
  logic [7:0] red_holding;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] sec_remaining;
  logic       sec_tick;

  modport master (
    output sim_state, green_duration, yellow_duration, red_holding,
    input  ns_light, ew_light, phase, sec_remaining, sec_tick
  );

  modport slave (
    input  sim_state, green_duration, yellow_duration, red_holding,
    output ns_light, ew_light, phase, sec_remaining, sec_tick
  );
endinterface

// File: rtl/traffic_light_sequencer_sec_prescaler.sv
// One-second prescaler. Counts 0..TICKS_PER_SEC-1 while run is high, holds
// its count otherwise, and clears to 0 on clear. tick flags the cycle whose
// closing edge wraps the count, so the consumer acts on that same edge.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count and wrap strobe; clear has priority over run
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Two-road traffic light sequencer: phase FSM, per-phase seconds countdown
// and registered lamp decode, paced by the one-second prescaler.
//
//   state        | meaning
//   -------------+----------------------------------------------
//   PH_IDLE      | stopped, both roads red, countdown 0
//   PH_NS_GREEN  | NS green, EW red, green_duration seconds
//   PH_NS_YELLOW | NS yellow, EW red, yellow_duration seconds
//   PH_RED_A     | all red clearance, red_holding seconds
//   PH_EW_GREEN  | EW green, NS red, green_duration seconds
//   PH_EW_YELLOW | EW yellow, NS red, yellow_duration seconds
//   PH_RED_B     | all red clearance, red_holding seconds
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input logic                      clk,
  input logic                      reset,
  traffic_light_sequencer_if.slave bus
);

  phase_e     phase_q, phase_d;
  logic [7:0] sec_q, sec_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       tick_q;
  logic       is_play, is_pause;
  logic       run, clear, tick;

  assign is_play  = (bus.sim_state == SIM_PLAY);
  assign is_pause = (bus.sim_state == SIM_PAUSE);
  // Code 3 falls through to STOP
  assign clear    = !is_play && !is_pause;
  assign run      = is_play && (phase_q != PH_IDLE);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clear(clear),
    .tick (tick)
  );

  // Next phase and countdown; durations are sampled only on phase entry.
  // Lamps decode the next phase so they change on the same edge as phase.
  always_comb begin
    phase_d = phase_q;
    sec_d   = sec_q;
    if (clear) begin
      phase_d = PH_IDLE;
      sec_d   = 8'd0;
    end else if (is_play) begin
      if (phase_q == PH_IDLE) begin
        phase_d = PH_NS_GREEN;
        sec_d   = sat_dur(bus.green_duration);
      end else if (tick) begin
        if (sec_q <= 8'd1) begin
          phase_d = next_phase(phase_q);
          sec_d   = phase_duration(phase_d, bus.green_duration,
                                   bus.yellow_duration, bus.red_holding);
        end else begin
          sec_d = sec_q - 8'd1;
        end
      end
    end
    ns_d = ns_lamp(phase_d);
    ew_d = ew_lamp(phase_d);
  end

  // State, countdown, lamp and tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      sec_q   <= 8'd0;
      ns_q    <= RED;
      ew_q    <= RED;
      tick_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sec_q   <= sec_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      tick_q  <= tick;
    end
  end

  assign bus.phase         = phase_q;
  assign bus.sec_remaining = sec_q;
  assign bus.ns_light      = ns_q;
  assign bus.ew_light      = ew_q;
  assign bus.sec_tick      = tick_q;

endmodule
